// File: rtl/md5_pkg.sv
// Shared MD5 definitions: state/block types, IV, round constants, shift amounts,
// message-index and round-function helpers, and the 32-bit byte swap.
package md5_pkg;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
   } md5_state_t;

   // Element j holds little-endian message word M[j].
   typedef logic [15:0][31:0] md5_block_t;

   typedef enum logic {
      MODE_IDLE,
      MODE_STREAM
   } md5_mode_e;

   localparam int NUM_STEPS = 64;

   localparam logic [31:0] IV_A = 32'h67452301;
   localparam logic [31:0] IV_B = 32'hefcdab89;
   localparam logic [31:0] IV_C = 32'h98badcfe;
   localparam logic [31:0] IV_D = 32'h10325476;

   localparam md5_state_t IV = '{a: IV_A, b: IV_B, c: IV_C, d: IV_D};

   localparam logic [31:0] K_TAB [0:63] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   localparam logic [4:0] S_TAB [0:63] = '{
      5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
      5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
      5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
      5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
      5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
      5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
      5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
      5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
   };

   function automatic int md5_g(input int step);
      if (step < 16)      return step;
      else if (step < 32) return (5 * step + 1) % 16;
      else if (step < 48) return (3 * step + 5) % 16;
      else                return (7 * step) % 16;
   endfunction

   function automatic logic [31:0] md5_round_fn(input int step, input logic [31:0] b,
                                                input logic [31:0] c, input logic [31:0] d);
      case (step / 16)
         0:       return (b & c) | (~b & d);
         1:       return (d & b) | (~d & c);
         2:       return b ^ c ^ d;
         default: return c ^ (b | ~d);
      endcase
   endfunction

   function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

endpackage

// File: rtl/md5_pipeline_if.sv
// Block-in / digest-out bundle of the MD5 pipeline; master is the host-side
// packer, slave is the core.
interface md5_pipeline_if;
   logic         i_start;
   logic         last512;
   logic [511:0] i_data;
   logic [127:0] o_data;
   logic         o_fBusy;
   logic         o_fDone;

   modport master (output i_start, last512, i_data, input o_data, o_fBusy, o_fDone);
   modport slave  (input i_start, last512, i_data, output o_data, o_fBusy, o_fDone);
endinterface

// File: rtl/md5_step.sv
// One registered MD5 step; STEP selects round function, K, shift and message word.
// The block travels alongside the state so every stage is self-contained.
module md5_step
   import md5_pkg::*;
#(
   parameter int STEP = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  md5_state_t in_state,
   input  md5_block_t in_block,
   output logic       out_valid,
   output md5_state_t out_state,
   output md5_block_t out_block
);

   localparam logic [31:0] K_I   = K_TAB[6'(STEP)];
   localparam int unsigned SH_I  = int'(S_TAB[6'(STEP)]);
   localparam logic [3:0]  G_IDX = 4'(md5_g(STEP));

   logic [31:0] sum;
   logic [31:0] new_b;

   always_comb begin
      // NOTE: assign every always_comb output unconditionally first so no path
      // leaves a value held over, which would infer a latch.
      sum   = '0;
      new_b = '0;
      sum   = md5_round_fn(STEP, in_state.b, in_state.c, in_state.d)
              + in_state.a + K_I + in_block[G_IDX];
      new_b = in_state.b + rotl32(sum, SH_I);
   end

   // NOTE: registers use non-blocking assignments so every stage samples its
   // neighbour's pre-edge value; blocking here would race between stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_valid <= 1'b0;
      else        out_valid <= in_valid;
   end

   // NOTE: wide datapath registers are deliberately left out of reset; the
   // valid bit alone decides whether their contents mean anything.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         out_state <= '{a: in_state.d, b: new_b, c: in_state.b, d: in_state.c};
         out_block <= in_block;
      end
   end

endmodule

// File: rtl/md5_pipeline.sv
// Fully pipelined single-block MD5 core: one block in and one digest out per clock.
// Optional macro MD5_OUT_REG_EN registers the digest (latency 65 instead of 64).
module md5_pipeline
   import md5_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_reset,
   md5_pipeline_if.slave bus
);

   md5_mode_e  mode;
   logic       accept;
   logic       s0_valid;
   md5_block_t s0_block;
   md5_block_t msg_words;
   logic       any_valid;
   logic [127:0] digest;

   logic       stage_valid [0:NUM_STEPS];
   md5_state_t stage_state [0:NUM_STEPS];
   md5_block_t stage_block [0:NUM_STEPS];

   // i_start only matters in IDLE; in STREAM every edge takes a block.
   assign accept = bus.i_start | (mode == MODE_STREAM);

   always_comb begin
      msg_words = '0;
      for (int j = 0; j < 16; j++) begin
         msg_words[j] = bswap32(bus.i_data[511 - 32 * j -: 32]);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         mode     <= MODE_IDLE;
         s0_valid <= 1'b0;
      end else begin
         s0_valid <= accept;
         case (mode)
            MODE_IDLE:   if (bus.i_start && !bus.last512) mode <= MODE_STREAM;
            MODE_STREAM: if (bus.last512) mode <= MODE_IDLE;
            default:     mode <= MODE_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) s0_block <= msg_words;
   end

   // Every block is an independent message, so stage 0 always starts from IV.
   assign stage_valid[0] = s0_valid;
   assign stage_state[0] = IV;
   assign stage_block[0] = s0_block;

   for (genvar i = 0; i < NUM_STEPS; i++) begin : g_step
      md5_step #(.STEP(i)) u_step (
         .clk       (i_clk),
         .rst_n     (i_reset),
         .in_valid  (stage_valid[i]),
         .in_state  (stage_state[i]),
         .in_block  (stage_block[i]),
         .out_valid (stage_valid[i+1]),
         .out_state (stage_state[i+1]),
         .out_block (stage_block[i+1])
      );
   end

   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i <= NUM_STEPS; i++) any_valid = any_valid | stage_valid[i];
   end

   always_comb begin
      digest = {bswap32(IV_A + stage_state[NUM_STEPS].a),
                bswap32(IV_B + stage_state[NUM_STEPS].b),
                bswap32(IV_C + stage_state[NUM_STEPS].c),
                bswap32(IV_D + stage_state[NUM_STEPS].d)};
   end

`ifdef MD5_OUT_REG_EN
   logic [127:0] out_data;
   logic         out_valid;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= stage_valid[NUM_STEPS];
         out_data  <= stage_valid[NUM_STEPS] ? digest : '0;
      end
   end

   assign bus.o_data  = out_data;
   assign bus.o_fDone = out_valid;
   assign bus.o_fBusy = (mode == MODE_STREAM) | any_valid | out_valid;
`else
   assign bus.o_data  = stage_valid[NUM_STEPS] ? digest : '0;
   assign bus.o_fDone = stage_valid[NUM_STEPS];
   assign bus.o_fBusy = (mode == MODE_STREAM) | any_valid;
`endif

endmodule

// File: tb/tb_md5_pipeline.sv
// Directed bench for md5_pipeline: known-answer digests, latency, busy/done
// framing, mid-stream reset and ignored control inputs.
module tb_md5_pipeline;

`ifdef MD5_OUT_REG_EN
   localparam int LAT = 65;
`else
   localparam int LAT = 64;
`endif

   localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 32'h18000000, 32'h0};
   localparam logic [511:0] BLK_A     = {32'h61800000, 416'h0, 32'h08000000, 32'h0};
   localparam logic [511:0] BLK_AB    = {32'h61628000, 416'h0, 32'h10000000, 32'h0};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 416'h0, 32'h00000000, 32'h0};

   localparam logic [127:0] DIG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
   localparam logic [127:0] DIG_A     = 128'h0cc175b9c0f1b6a831c399e269772661;
   localparam logic [127:0] DIG_AB    = 128'h187ef4436122d1cc2f40dc2b92f0eba0;
   localparam logic [127:0] DIG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;

   logic clk;
   logic rst_n;
   md5_pipeline_if bus ();

   md5_pipeline dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [511:0] stim_blk [3];
   logic [127:0] stim_dig [3];

   // Results of the most recent run_stream call.
   int           rs_done;
   int           rs_err;
   int           rs_first_k;
   int           rs_last_k;
   int           rs_busy_gaps;
   logic         rs_busy_after;
   logic [127:0] rs_bad_got;
   logic [127:0] rs_bad_exp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_idle();
      bus.i_start = 1'b0;
      bus.last512 = 1'b0;
      bus.i_data  = '0;
   endtask

   // Feeds n blocks (stim_blk cycling with the given period) and records every
   // output cycle; k counts edges from the first accepting edge (k=1).
   task automatic run_stream(input int n, input int period, input int repulse_at);
      rs_done = 0; rs_err = 0; rs_first_k = -1; rs_last_k = -1;
      rs_busy_gaps = 0; rs_busy_after = 1'bx; rs_bad_got = '0; rs_bad_exp = '0;
      fork
         begin
            for (int i = 0; i < n; i++) begin
               bus.i_start = (i == 0) || (i == repulse_at);
               bus.last512 = (i == n - 1);
               bus.i_data  = stim_blk[i % period];
               @(posedge clk); #1;
            end
            drive_idle();
         end
         begin
            for (int k = 1; k <= n + LAT + 8; k++) begin
               @(posedge clk); #1;
               if (bus.o_fDone === 1'b1) begin
                  if (rs_done == 0) rs_first_k = k;
                  rs_last_k = k;
                  if (bus.o_data !== stim_dig[rs_done % period]) begin
                     if (rs_err == 0) begin
                        rs_bad_got = bus.o_data;
                        rs_bad_exp = stim_dig[rs_done % period];
                     end
                     rs_err++;
                  end
                  rs_done++;
               end else if (bus.o_data !== 128'h0) begin
                  if (rs_err == 0) begin
                     rs_bad_got = bus.o_data;
                     rs_bad_exp = '0;
                  end
                  rs_err++;
               end
               if (k <= n + LAT && bus.o_fBusy !== 1'b1) rs_busy_gaps++;
               if (k == n + LAT + 1) rs_busy_after = bus.o_fBusy;
            end
         end
      join
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      #15;
      total_cnt++; if (bus.o_fDone !== 1'b0) $display("FAIL reset_done_low: got %b want 0", bus.o_fDone); else pass_cnt++;
      total_cnt++; if (bus.o_fBusy !== 1'b0) $display("FAIL reset_busy_low: got %b want 0", bus.o_fBusy); else pass_cnt++;
      total_cnt++; if (bus.o_data !== 128'h0) $display("FAIL reset_data_low: got %h want 0", bus.o_data); else pass_cnt++;
      #5 rst_n = 1'b1;
      @(posedge clk); #1;
      total_cnt++; if (bus.o_fDone !== 1'b0) $display("FAIL post_reset_done: got %b want 0", bus.o_fDone); else pass_cnt++;
      total_cnt++; if (bus.o_fBusy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", bus.o_fBusy); else pass_cnt++;
      total_cnt++; if (bus.o_data !== 128'h0) $display("FAIL post_reset_data: got %h want 0", bus.o_data); else pass_cnt++;
   endtask

   // One block with i_start and last512 together: accepted while staying IDLE.
   task automatic test_single(input string name, input logic [511:0] blk, input logic [127:0] dig);
      stim_blk[0] = blk;
      stim_dig[0] = dig;
      run_stream(1, 1, -1);
      total_cnt++; if (rs_done !== 1) $display("FAIL %s_done_count: got %0d want 1", name, rs_done); else pass_cnt++;
      total_cnt++; if (rs_err !== 0) $display("FAIL %s_digest: got %h want %h", name, rs_bad_got, rs_bad_exp); else pass_cnt++;
      total_cnt++; if (rs_first_k !== 1 + LAT) $display("FAIL %s_latency: got %0d want %0d", name, rs_first_k, 1 + LAT); else pass_cnt++;
      total_cnt++; if (rs_busy_gaps !== 0) $display("FAIL %s_busy_held: got %0d low cycles want 0", name, rs_busy_gaps); else pass_cnt++;
      total_cnt++; if (rs_busy_after !== 1'b0) $display("FAIL %s_busy_fall: got %b want 0", name, rs_busy_after); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      stim_blk[0] = BLK_ABC; stim_blk[1] = BLK_A; stim_blk[2] = BLK_AB;
      stim_dig[0] = DIG_ABC; stim_dig[1] = DIG_A; stim_dig[2] = DIG_AB;
      run_stream(60, 3, -1);
      total_cnt++; if (rs_done !== 60) $display("FAIL stream_done_count: got %0d want 60", rs_done); else pass_cnt++;
      total_cnt++; if (rs_err !== 0) $display("FAIL stream_digest: got %h want %h (errors %0d)", rs_bad_got, rs_bad_exp, rs_err); else pass_cnt++;
      total_cnt++; if (rs_first_k !== 1 + LAT) $display("FAIL stream_first_done: got %0d want %0d", rs_first_k, 1 + LAT); else pass_cnt++;
      total_cnt++; if (rs_last_k !== 60 + LAT) $display("FAIL stream_last_done: got %0d want %0d", rs_last_k, 60 + LAT); else pass_cnt++;
      total_cnt++; if (rs_busy_gaps !== 0) $display("FAIL stream_busy_held: got %0d low cycles want 0", rs_busy_gaps); else pass_cnt++;
      total_cnt++; if (rs_busy_after !== 1'b0) $display("FAIL stream_busy_fall: got %b want 0", rs_busy_after); else pass_cnt++;
   endtask

   task automatic test_restart_ignored();
      stim_blk[0] = BLK_AB; stim_blk[1] = BLK_ABC; stim_blk[2] = BLK_A;
      stim_dig[0] = DIG_AB; stim_dig[1] = DIG_ABC; stim_dig[2] = DIG_A;
      run_stream(20, 3, 7);
      total_cnt++; if (rs_done !== 20) $display("FAIL restart_done_count: got %0d want 20", rs_done); else pass_cnt++;
      total_cnt++; if (rs_err !== 0) $display("FAIL restart_digest: got %h want %h", rs_bad_got, rs_bad_exp); else pass_cnt++;
      total_cnt++; if (rs_last_k !== 20 + LAT) $display("FAIL restart_last_done: got %0d want %0d", rs_last_k, 20 + LAT); else pass_cnt++;
      total_cnt++; if (rs_busy_after !== 1'b0) $display("FAIL restart_busy_fall: got %b want 0", rs_busy_after); else pass_cnt++;
   endtask

   task automatic test_reset_mid_stream();
      logic busy_pre;
      int   done_seen;
      int   busy_seen;
      for (int i = 0; i < 30; i++) begin
         bus.i_start = (i == 0);
         bus.last512 = 1'b0;
         bus.i_data  = BLK_A;
         @(posedge clk); #1;
      end
      busy_pre = bus.o_fBusy;
      #2;
      rst_n = 1'b0;
      drive_idle();
      #1;
      total_cnt++; if (busy_pre !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy_pre); else pass_cnt++;
      total_cnt++; if (bus.o_fBusy !== 1'b0) $display("FAIL midrst_busy_async: got %b want 0", bus.o_fBusy); else pass_cnt++;
      total_cnt++; if (bus.o_fDone !== 1'b0) $display("FAIL midrst_done_async: got %b want 0", bus.o_fDone); else pass_cnt++;
      total_cnt++; if (bus.o_data !== 128'h0) $display("FAIL midrst_data_async: got %h want 0", bus.o_data); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      busy_seen = 0;
      for (int k = 0; k < LAT + 40; k++) begin
         @(posedge clk); #1;
         if (bus.o_fDone !== 1'b0) done_seen++;
         if (bus.o_fBusy !== 1'b0) busy_seen++;
      end
      total_cnt++; if (done_seen !== 0) $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); else pass_cnt++;
      total_cnt++; if (busy_seen !== 0) $display("FAIL midrst_no_busy: got %0d busy cycles want 0", busy_seen); else pass_cnt++;
   endtask

   // last512 without i_start in IDLE must not accept anything.
   task automatic test_ignored_last512();
      int done_seen;
      int busy_seen;
      done_seen = 0;
      busy_seen = 0;
      for (int i = 0; i < 3; i++) begin
         bus.i_start = 1'b0;
         bus.last512 = 1'b1;
         bus.i_data  = BLK_A;
         @(posedge clk); #1;
         if (bus.o_fBusy !== 1'b0) busy_seen++;
      end
      drive_idle();
      for (int k = 0; k < LAT + 8; k++) begin
         @(posedge clk); #1;
         if (bus.o_fDone !== 1'b0) done_seen++;
         if (bus.o_fBusy !== 1'b0) busy_seen++;
      end
      total_cnt++; if (done_seen !== 0) $display("FAIL lastonly_no_done: got %0d pulses want 0", done_seen); else pass_cnt++;
      total_cnt++; if (busy_seen !== 0) $display("FAIL lastonly_no_busy: got %0d busy cycles want 0", busy_seen); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single("single_a", BLK_A, DIG_A);
      test_back_to_back();
      test_single("empty", BLK_EMPTY, DIG_EMPTY);
      test_reset_mid_stream();
      test_restart_ignored();
      test_ignored_last512();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
